// File: rtl/sram_like_data_slave.sv
// sram_like_data_slave
//   Responder end of the CPU data-side sram-like interface. Backs load/store
//   requests with an internal word-addressed memory of 2^ADDR_WIDTH 32-bit
//   words. Requests are accepted in order, and up to DEPTH of them may be
//   outstanding at once. Each request is answered by exactly one data_ok,
//   no earlier than LAT cycles after it was accepted.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   data_sram_en         request valid
//   data_sram_wen        byte write strobes (nonzero = write, zero = read)
//   data_sram_size       0 byte, 1 half, 2/3 word (only used for the misalign check)
//   data_sram_addr       byte address; word index is addr[ADDR_WIDTH+1:2]
//   data_sram_wdata      write data, already lane-aligned by the requester
//   data_sram_addr_ok    request accepted this cycle when en=1
//   data_sram_data_ok    response for the oldest outstanding request
//   data_sram_rdata      read data while data_ok=1, otherwise 0
//   addr_stall           back-pressure input, forces addr_ok=0
//   resp_stall           back-pressure input, forces data_ok=0
//   outstanding          number of accepted requests not yet answered
//   err_misalign         sticky flag, set by any accepted misaligned request
module sram_like_data_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int LAT        = 2,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       data_sram_en,
  input  logic [3:0]                 data_sram_wen,
  input  logic [1:0]                 data_sram_size,
  input  logic [31:0]                data_sram_addr,
  input  logic [31:0]                data_sram_wdata,
  output logic                       data_sram_addr_ok,
  output logic                       data_sram_data_ok,
  output logic [31:0]                data_sram_rdata,
  input  logic                       addr_stall,
  input  logic                       resp_stall,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       err_misalign
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] LAT_AGE = 3'(LAT);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  // Response queue: one entry per accepted request, popped in order.
  logic        q_is_write [DEPTH];
  logic [31:0] q_rdata    [DEPTH];
  logic [2:0]  q_age      [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  is_write;
  logic                  accept;
  logic                  pop;
  logic                  head_ready;
  logic                  misaligned;
  logic                  unused_addr_hi;

  assign word_idx       = data_sram_addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = ^data_sram_addr[31:ADDR_WIDTH+2];
  assign is_write       = |data_sram_wen;

  // size 3 is checked like a word access
  always_comb begin
    misaligned = 1'b0;
    if (data_sram_size[1])
      misaligned = (data_sram_addr[1:0] != 2'b00);
    else if (data_sram_size == 2'd1)
      misaligned = data_sram_addr[0];
  end

  assign head_ready        = (count != '0) && (q_age[rd_ptr] >= LAT_AGE);
  assign data_sram_data_ok = !reset && head_ready && !resp_stall;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign data_sram_addr_ok = !reset && !addr_stall &&
                             ((count < CNT_W'(DEPTH)) || data_sram_data_ok);
  assign accept            = data_sram_en && data_sram_addr_ok;
  assign pop               = data_sram_data_ok;

  assign data_sram_rdata = (data_sram_data_ok && !q_is_write[rd_ptr]) ?
                           q_rdata[rd_ptr] : 32'h0;
  assign outstanding     = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_misalign <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_is_write[i] <= 1'b0;
        q_rdata[i]    <= 32'h0;
        q_age[i]      <= 3'd0;
      end
    end else begin
      // Ages of free slots also tick; they are overwritten on enqueue.
      for (int i = 0; i < DEPTH; i++) begin
        if (q_age[i] < LAT_AGE)
          q_age[i] <= q_age[i] + 3'd1;
      end
      if (accept) begin
        q_is_write[wr_ptr] <= is_write;
        q_rdata[wr_ptr]    <= is_write ? 32'h0 : mem[word_idx];
        q_age[wr_ptr]      <= 3'd1;
        wr_ptr             <= wr_ptr + PTR_W'(1);
        if (misaligned)
          err_misalign <= 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Memory is not reset; writes made before a reset survive it.
  always_ff @(posedge clk) begin
    if (accept && is_write) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wen[b])
          mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_data_slave.sv
module tb_sram_like_data_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        addr_stall;
  logic        resp_stall;
  logic [2:0]  outstanding;
  logic        err_misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_like_data_slave #(.ADDR_WIDTH(10), .LAT(2), .DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .data_sram_en      (en),
    .data_sram_wen     (wen),
    .data_sram_size    (size),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .addr_stall        (addr_stall),
    .resp_stall        (resp_stall),
    .outstanding       (outstanding),
    .err_misalign      (err_misalign)
  );

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        astall;
    logic        rstall;
    logic        e_aok;
    logic        e_dok;
    logic [31:0] e_rdata;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; size = s; addr = a; wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 2'd2, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr_stall = 1'b0; resp_stall = 1'b0;
    idle();

    // write/read, byte strobes, misalign, addr_stall
    tbl[0]  = '{1'b1, 4'hF, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'h0, 2'd2, 32'h10, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        3'd1, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 2'd2, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        3'd2, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 2'd2, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 3'd1, 1'b0};
    tbl[4]  = '{1'b1, 4'hF, 2'd2, 32'h20, 32'h11223344, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[5]  = '{1'b1, 4'h4, 2'd2, 32'h20, 32'h00AA0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        3'd1, 1'b0};
    tbl[6]  = '{1'b1, 4'h0, 2'd2, 32'h20, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        3'd2, 1'b0};
    tbl[7]  = '{1'b1, 4'h0, 2'd2, 32'h13, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        3'd2, 1'b0};
    tbl[8]  = '{1'b1, 4'h0, 2'd1, 32'h12, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h11AA3344, 3'd2, 1'b1};
    tbl[9]  = '{1'b0, 4'h0, 2'd2, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 3'd2, 1'b1};
    tbl[10] = '{1'b0, 4'h0, 2'd2, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 3'd1, 1'b1};
    tbl[11] = '{1'b0, 4'h0, 2'd2, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b1};
    tbl[12] = '{1'b1, 4'h0, 2'd2, 32'h10, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1};
    tbl[13] = '{1'b0, 4'h0, 2'd2, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b1};

    repeat (3) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_data_ok", 32'(data_ok), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err_misalign), 32'd0);
    chk("rst_addr_ok", 32'(addr_ok), 32'd1);
    next_cycle();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].wen, tbl[i].size, tbl[i].addr, tbl[i].wdata);
      addr_stall = tbl[i].astall;
      resp_stall = tbl[i].rstall;
      @(negedge clk);
      chk($sformatf("v%0d_addr_ok", i), 32'(addr_ok), 32'(tbl[i].e_aok));
      chk($sformatf("v%0d_data_ok", i), 32'(data_ok), 32'(tbl[i].e_dok));
      chk($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rdata);
      chk($sformatf("v%0d_outstanding", i), 32'(outstanding), 32'(tbl[i].e_out));
      chk($sformatf("v%0d_err", i), 32'(err_misalign), 32'(tbl[i].e_err));
      next_cycle();
    end
    addr_stall = 1'b0;
    resp_stall = 1'b0;

    // Streaming: 8 back-to-back writes, then 8 back-to-back reads (LAT=2)
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 11; i++) begin
        logic        e_dok;
        logic [31:0] e_rd;
        int          e_out;
        if (i < 8)
          drive(1'b1, (pass == 0) ? 4'hF : 4'h0, 2'd2, 32'h40 + 32'(4 * i), 32'hA5000000 + 32'(i));
        else
          idle();
        e_dok = (i >= 2) && (i < 10);
        e_rd  = (e_dok && pass == 1) ? 32'hA5000000 + 32'(i - 2) : 32'h0;
        e_out = (i == 0) ? 0 : (i == 1) ? 1 : (i <= 8) ? 2 : (i == 9) ? 1 : 0;
        @(negedge clk);
        chk($sformatf("stream%0d_c%0d_data_ok", pass, i), 32'(data_ok), 32'(e_dok));
        chk($sformatf("stream%0d_c%0d_rdata", pass, i), rdata, e_rd);
        chk($sformatf("stream%0d_c%0d_outstanding", pass, i), 32'(outstanding), 32'(e_out));
        next_cycle();
      end
    end

    // Fill to DEPTH under resp_stall, then pop-through on release
    resp_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h0, 2'd2, 32'h40 + 32'(4 * i), 32'h0);
      @(negedge clk);
      chk($sformatf("fill%0d_addr_ok", i), 32'(addr_ok), 32'd1);
      chk($sformatf("fill%0d_outstanding", i), 32'(outstanding), 32'(i));
      chk($sformatf("fill%0d_data_ok", i), 32'(data_ok), 32'd0);
      next_cycle();
    end
    drive(1'b1, 4'h0, 2'd2, 32'h50, 32'h0);
    @(negedge clk);
    chk("full_addr_ok", 32'(addr_ok), 32'd0);
    chk("full_outstanding", 32'(outstanding), 32'd4);
    chk("full_data_ok", 32'(data_ok), 32'd0);
    next_cycle();
    resp_stall = 1'b0;
    @(negedge clk);
    chk("popthru_data_ok", 32'(data_ok), 32'd1);
    chk("popthru_addr_ok", 32'(addr_ok), 32'd1);
    chk("popthru_rdata", rdata, 32'hA5000000);
    chk("popthru_outstanding", 32'(outstanding), 32'd4);
    next_cycle();
    idle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_data_ok", k), 32'(data_ok), 32'd1);
      chk($sformatf("drain%0d_rdata", k), rdata, 32'hA5000000 + 32'(k));
      chk($sformatf("drain%0d_outstanding", k), 32'(outstanding), 32'(5 - k));
      next_cycle();
    end
    @(negedge clk);
    chk("drained_outstanding", 32'(outstanding), 32'd0);
    chk("drained_data_ok", 32'(data_ok), 32'd0);
    next_cycle();

    // Reset mid-flight
    drive(1'b1, 4'hF, 2'd2, 32'h80, 32'hCAFEF00D);
    next_cycle();
    idle();
    repeat (3) next_cycle();
    resp_stall = 1'b1;
    drive(1'b1, 4'h0, 2'd2, 32'h40, 32'h0);
    next_cycle();
    drive(1'b1, 4'h0, 2'd2, 32'h44, 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("prerst_outstanding", 32'(outstanding), 32'd2);
    chk("prerst_err", 32'(err_misalign), 32'd1);
    next_cycle();
    reset = 1'b1;
    resp_stall = 1'b0;
    drive(1'b1, 4'h0, 2'd2, 32'h80, 32'h0);
    @(negedge clk);
    chk("inrst_addr_ok", 32'(addr_ok), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("postrst_outstanding", 32'(outstanding), 32'd0);
    chk("postrst_err", 32'(err_misalign), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("postrst%0d_data_ok", i), 32'(data_ok), 32'd0);
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
    drive(1'b1, 4'h0, 2'd2, 32'h80, 32'h0);
    @(negedge clk);
    chk("keep_addr_ok", 32'(addr_ok), 32'd1);
    next_cycle();
    drive(1'b1, 4'h0, 2'd1, 32'h11, 32'h0);
    @(negedge clk);
    chk("keep_early_data_ok", 32'(data_ok), 32'd0);
    chk("misal_half_err_before", 32'(err_misalign), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("keep_data_ok", 32'(data_ok), 32'd1);
    chk("keep_rdata", rdata, 32'hCAFEF00D);
    chk("misal_half_err_after", 32'(err_misalign), 32'd1);
    next_cycle();
    repeat (3) next_cycle();
    @(negedge clk);
    chk("final_outstanding", 32'(outstanding), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
